hdb3_tx_sched: RTL and testbench



---
 rtl/hdb3_pkg.sv | 28 ++
 rtl/hdb3_tag_delay.sv | 29 ++
 rtl/hdb3_tx_sched.sv | 212 +++++++++++++++++++++
 tb/tb_hdb3_tx_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared types and constants for the HDB3 transmit chain: scheduler states,
// encoder symbol codes, the symbol tag payload and the default pipeline latency.
package hdb3_pkg;

    localparam int unsigned PIPE_LAT_DEFAULT = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FLUSH = 2'd3
    } sched_state_e;

    // Symbol codes exchanged between the V-insertion and B-insertion stages
    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_V    = 2'b10,
        SYM_B    = 2'b11
    } sym_e;

    typedef struct packed {
        logic data;
        logic ch;
        logic eof;
    } sym_tag_t;

endpackage

// File: rtl/hdb3_tag_delay.sv
// Fixed-depth delay line aligning scheduler tags with the encoded symbol that
// leaves the chain DEPTH clocks after the raw bit.
module hdb3_tag_delay
    import hdb3_pkg::*;
#(
    parameter int unsigned DEPTH = PIPE_LAT_DEFAULT
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  sym_tag_t tag_in,
    output sym_tag_t tag_out
);

    sym_tag_t [DEPTH-1:0] line_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_q <= '0;
        end else begin
            line_q[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/hdb3_tx_sched.sv
// Round-robin frame scheduler and MSB-first serialiser feeding the HDB3 encoder.
// Optional underrun abort watchdog: define HDB3_SCHED_TIMEOUT_EN.
module hdb3_tx_sched
    import hdb3_pkg::*;
#(
    parameter int unsigned PIPE_LAT  = PIPE_LAT_DEFAULT,
    parameter int unsigned FLUSH_LEN = 8
`ifdef HDB3_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 64
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic       o_enc_bit,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_underrun,
    output logic       o_sym_data,
    output logic       o_sym_ch,
    output logic       o_sym_eof
`ifdef HDB3_SCHED_TIMEOUT_EN
    ,
    output logic       o_abort
`endif
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned FLUSH_W = 8;
`ifdef HDB3_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    sched_state_e       state_q, state_d;
    logic               gch_q, gch_d;
    logic               ptr_q, ptr_d;
    logic               last_q, last_d;
    logic               started_q, started_d;
    logic [BYTE_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
`ifdef HDB3_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]    to_q, to_d;
    logic               abort_d;
`endif

    logic               enc_d, busy_d, underrun_d, rdy_d, rdy0_d, rdy1_d;
    logic [1:0]         grant_d;
    sym_tag_t           tag_d, tag_q, tag_dly;

    logic               hs;
    logic [BYTE_W-1:0]  in_data;
    logic               in_last;

    // Only the granted channel can ever see ready, so its handshake is the only one
    assign hs      = gch_q ? (i_req1_valid & o_req1_ready) : (i_req0_valid & o_req0_ready);
    assign in_data = gch_q ? i_req1_data : i_req0_data;
    assign in_last = gch_q ? i_req1_last : i_req0_last;

    // Next-state logic; outputs are derived from the next state and registered
    always_comb begin
        state_d   = state_q;
        gch_d     = gch_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        started_d = started_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        flush_d   = flush_q;
`ifdef HDB3_SCHED_TIMEOUT_EN
        to_d      = to_q;
        abort_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    gch_d     = ptr_q ? i_req1_valid : !i_req0_valid;
                    ptr_d     = !gch_d;
                    started_d = 1'b0;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hs) begin
                    shreg_d = in_data;
                    last_d  = in_last;
                    idx_d   = IDX_W'(7);
                    state_d = ST_SHIFT;
                end
`ifdef HDB3_SCHED_TIMEOUT_EN
                else if (started_q) begin
                    if (to_q == TO_W'(TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        flush_d = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
`endif
            end
            ST_SHIFT: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (last_q) begin
                    flush_d = '0;
                    state_d = ST_FLUSH;
                end else if (hs) begin
                    shreg_d = in_data;
                    last_d  = in_last;
                    idx_d   = IDX_W'(7);
                end else begin
                    started_d = 1'b1;
                    state_d   = ST_GRANT;
`ifdef HDB3_SCHED_TIMEOUT_EN
                    to_d      = '0;
`endif
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_W'(FLUSH_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        grant_d    = (state_d == ST_IDLE) ? 2'b00 : (gch_d ? 2'b10 : 2'b01);
        rdy_d      = (state_d == ST_GRANT) ||
                     ((state_d == ST_SHIFT) && (idx_d == '0) && !last_d);
        rdy0_d     = rdy_d && !gch_d;
        rdy1_d     = rdy_d && gch_d;
        enc_d      = (state_d == ST_SHIFT) && shreg_d[idx_d];
        underrun_d = (state_d == ST_GRANT) && started_d;
        tag_d.data = (state_d == ST_SHIFT);
        tag_d.ch   = tag_d.data && gch_d;
        tag_d.eof  = tag_d.data && (idx_d == '0) && last_d;
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            gch_q        <= 1'b0;
            ptr_q        <= 1'b0;
            last_q       <= 1'b0;
            started_q    <= 1'b0;
            shreg_q      <= '0;
            idx_q        <= '0;
            flush_q      <= '0;
            o_enc_bit    <= 1'b0;
            o_grant      <= 2'b00;
            o_busy       <= 1'b0;
            o_underrun   <= 1'b0;
            o_req0_ready <= 1'b0;
            o_req1_ready <= 1'b0;
            tag_q        <= '0;
`ifdef HDB3_SCHED_TIMEOUT_EN
            to_q         <= '0;
            o_abort      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gch_q        <= gch_d;
            ptr_q        <= ptr_d;
            last_q       <= last_d;
            started_q    <= started_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            flush_q      <= flush_d;
            o_enc_bit    <= enc_d;
            o_grant      <= grant_d;
            o_busy       <= busy_d;
            o_underrun   <= underrun_d;
            o_req0_ready <= rdy0_d;
            o_req1_ready <= rdy1_d;
            tag_q        <= tag_d;
`ifdef HDB3_SCHED_TIMEOUT_EN
            to_q         <= to_d;
            o_abort      <= abort_d;
`endif
        end
    end

    // tag_q travels alongside o_enc_bit, so the line delays it by the chain latency
    hdb3_tag_delay #(
        .DEPTH (PIPE_LAT)
    ) u_tag_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .tag_in  (tag_q),
        .tag_out (tag_dly)
    );

    assign o_sym_data = tag_dly.data;
    assign o_sym_ch   = tag_dly.ch;
    assign o_sym_eof  = tag_dly.eof;

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Bench for hdb3_tx_sched: frames are expanded into a per-cycle timeline of
// requester drives and expected outputs, then replayed against the DUT.
module tb_hdb3_tx_sched;

    localparam int PIPE_LAT  = 9;
    localparam int FLUSH_LEN = 8;
    localparam int MAXT      = 8192;

    logic       clk;
    logic       rst_n;
    logic       v0, l0, v1, l1;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, enc, busy, ur, sd, sc, se;
    logic [1:0] grant;
`ifdef HDB3_SCHED_TIMEOUT_EN
    logic       abort;
`endif

    hdb3_tx_sched #(
        .PIPE_LAT  (PIPE_LAT),
        .FLUSH_LEN (FLUSH_LEN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (v0),
        .i_req0_data  (d0),
        .i_req0_last  (l0),
        .o_req0_ready (rdy0),
        .i_req1_valid (v1),
        .i_req1_data  (d1),
        .i_req1_last  (l1),
        .o_req1_ready (rdy1),
        .o_enc_bit    (enc),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_underrun   (ur),
        .o_sym_data   (sd),
        .o_sym_ch     (sc),
        .o_sym_eof    (se)
`ifdef HDB3_SCHED_TIMEOUT_EN
        ,
        .o_abort      (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline: exp_o = {enc, grant[1:0], busy, underrun, rdy1, rdy0}, exp_tag = {data, ch, eof}
    logic [6:0] exp_o   [MAXT];
    logic [2:0] exp_tag [MAXT];
    logic       drv_v   [2][MAXT];
    logic [7:0] drv_d   [2][MAXT];
    logic       drv_l   [2][MAXT];

    logic [7:0] fb [2][3];
    int         fn [2];
    int         fg [2][3];
    int         tcur;
    logic       ptr_m;
    int         nvec;
    int         nerr;

    function automatic logic [9:0] obs();
        return {enc, grant, busy, ur, rdy1, rdy0, sd, sc, se};
    endfunction

    task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic clear_model();
        for (int t = 0; t < MAXT; t++) begin
            exp_o[t]   = '0;
            exp_tag[t] = '0;
            for (int c = 0; c < 2; c++) begin
                drv_v[c][t] = 1'b0;
                drv_d[c][t] = 8'($urandom);
                drv_l[c][t] = 1'($urandom);
            end
        end
        tcur = 0;
    endtask

    task automatic drive(input int c, input int t, input logic v, input logic [7:0] d, input logic l);
        drv_v[c][t] = v;
        drv_d[c][t] = d;
        drv_l[c][t] = l;
    endtask

    task automatic busy_cycle(input int t, input int c, input logic e, input logic u,
                              input logic r, input logic td, input logic te);
        exp_o[t]   = {e, (c == 1) ? 2'b10 : 2'b01, 1'b1, u, r && (c == 1), r && (c == 0)};
        exp_tag[t] = {td, td && (c == 1), te};
    endtask

    task automatic set_frame(input int c, input int n, input logic [23:0] bytes, input int g1, input int g2);
        fn[c]    = n;
        fb[c][0] = bytes[23:16];
        fb[c][1] = bytes[15:8];
        fb[c][2] = bytes[7:0];
        fg[c][0] = 0;
        fg[c][1] = g1;
        fg[c][2] = g2;
    endtask

    // One frame from the IDLE cycle at tcur: grant cycle, 8 bits per byte with
    // fg[c][i] inserted zero cycles before byte i, then the flush zeros.
    task automatic emit_frame(input int c);
        int         t;
        int         n;
        logic [7:0] cur;
        logic       rq;
        t = tcur;
        n = fn[c];
        drive(c, t, 1'b1, fb[c][0], n == 1);
        ptr_m = (c == 0);
        t++;
        busy_cycle(t, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(c, t, 1'b1, fb[c][0], n == 1);
        t++;
        for (int i = 0; i < n; i++) begin
            cur = fb[c][i];
            for (int k = 7; k >= 0; k--) begin
                rq = (k == 0) && (i != n - 1);
                busy_cycle(t, c, cur[k], 1'b0, rq, 1'b1, (k == 0) && (i == n - 1));
                if (rq) drive(c, t, fg[c][i+1] == 0, fb[c][i+1], i + 1 == n - 1);
                t++;
            end
            if (i != n - 1) begin
                for (int j = 1; j <= fg[c][i+1]; j++) begin
                    busy_cycle(t, c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                    if (j == fg[c][i+1]) drive(c, t, 1'b1, fb[c][i+1], i + 1 == n - 1);
                    t++;
                end
            end
        end
        for (int f = 0; f < FLUSH_LEN; f++) begin
            busy_cycle(t, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            t++;
        end
        tcur = t;
    endtask

    // Requests after `idle` quiet cycles; a simultaneous loser keeps its valid up until served
    task automatic scenario(input logic r0, input logic r1, input int idle);
        int ts;
        int first;
        tcur += idle;
        if (r0 && r1) begin
            first = ptr_m ? 1 : 0;
            ts    = tcur;
            emit_frame(first);
            for (int t = ts; t < tcur; t++) drive(1 - first, t, 1'b1, fb[1-first][0], fn[1-first] == 1);
            emit_frame(1 - first);
        end else begin
            emit_frame(r1 ? 1 : 0);
        end
    endtask

    task automatic run_range(input int t0, input int t1);
        for (int t = t0; t < t1; t++) begin
            @(posedge clk);
            #1;
            v0 = drv_v[0][t]; d0 = drv_d[0][t]; l0 = drv_l[0][t];
            v1 = drv_v[1][t]; d1 = drv_d[1][t]; l1 = drv_l[1][t];
            @(negedge clk);
            check($sformatf("cyc%0d", t), obs(),
                  {exp_o[t], (t >= PIPE_LAT) ? exp_tag[t-PIPE_LAT] : 3'b000});
        end
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; d0 = 8'h00; l0 = 1'b0;
        v1 = 1'b0; d1 = 8'h00; l1 = 1'b0;
    endtask

    initial begin
        int ts;
        int r;
        nvec  = 0;
        nerr  = 0;
        ptr_m = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset", obs(), 10'b0);
        rst_n = 1'b1;

        clear_model();
        tcur = 2;
        set_frame(0, 1, 24'hA50000, 0, 0);
        scenario(1'b1, 1'b0, 0);
        set_frame(0, 2, 24'h3CC300, 0, 0);
        set_frame(1, 2, 24'h5A9600, 0, 0);
        scenario(1'b1, 1'b1, 2);
        scenario(1'b1, 1'b1, 1);
        set_frame(1, 3, 24'hFF0081, 0, 0);
        scenario(1'b0, 1'b1, 3);
        set_frame(0, 2, 24'h0FE100, 5, 0);
        scenario(1'b1, 1'b0, 2);
        repeat (30) begin
            r = int'($urandom_range(1, 3));
            set_frame(0, int'($urandom_range(1, 3)), 24'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            set_frame(1, int'($urandom_range(1, 3)), 24'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            scenario(r[0], r[1], int'($urandom_range(0, 3)));
        end
        tcur += PIPE_LAT + 3;
        run_range(0, tcur);

        // Reset in the middle of a ch0 byte (bit index 3) with the pointer parked on ch1
        clear_model();
        tcur = 2;
        set_frame(1, 1, 24'h770000, 0, 0);
        scenario(1'b0, 1'b1, 0);
        set_frame(0, 2, 24'hB4D200, 0, 0);
        ts = tcur;
        scenario(1'b1, 1'b0, 0);
        run_range(0, ts + 7);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("reset_mid", obs(), 10'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        clear_model();
        ptr_m = 1'b0;
        tcur  = 1;
        set_frame(0, 1, 24'h660000, 0, 0);
        set_frame(1, 2, 24'h1EE100, 1, 0);
        scenario(1'b1, 1'b1, 0);
        tcur += PIPE_LAT + 3;
        run_range(0, tcur);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
